// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner.
// Holds the scan FSM state encoding, the digit-select width and the
// all-segments-off constant used while blanking.
package display_pkg;

    typedef enum logic {
        StBlank,
        StShow
    } state_e;

    localparam int unsigned SelWidth = 4;

    // Active-low outputs: all ones means every segment / digit is dark.
    localparam logic [7:0]          SegBlank = 8'hFF;
    localparam logic [SelWidth-1:0] SelNone  = '1;

endpackage

// File: rtl/BCD_n.sv
// BCD to active-low 7-segment decoder.
// Ports:
//   bcd - 4-bit BCD digit
//   seg - active-low segments {dp, g, f, e, d, c, b, a}; codes 10..15 are dark
module BCD_n
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SegBlank;
        case (bcd)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SegBlank;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment display scan controller.
// Each digit gets BLANK_CYCLES of dead time followed by DWELL_CYCLES of drive.
// New numbers are double-buffered and only take effect at a frame boundary.
// Optional macro DISP_LZ_SUPPRESS_EN darkens leading zero digits (digit 0 always shown).
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   enable        - scan enable; low blanks the display and parks the scanner
//   number_in     - packed BCD, digit 0 in bits [3:0]
//   load          - one-cycle strobe capturing number_in into the pending buffer
//   load_pending  - a loaded value has not reached the display yet
//   frame_done    - one-cycle pulse after the last digit of a frame
//   io_sel        - active-low digit select (registered)
//   io_seg        - active-low segments (registered)
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned NUMBER_OF_DIGITS = 4,
    parameter int unsigned DWELL_CYCLES     = 50000,
    parameter int unsigned BLANK_CYCLES     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [4*NUMBER_OF_DIGITS-1:0] number_in,
    input  logic                          load,
    output logic                          load_pending,
    output logic                          frame_done,
    output logic [SelWidth-1:0]           io_sel,
    output logic [7:0]                    io_seg
);

    localparam int unsigned W         = 4 * NUMBER_OF_DIGITS;
    localparam logic [31:0] DwellLast = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] BlankLast = 32'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [1:0]  LastIdx   = 2'(NUMBER_OF_DIGITS - 1);

    state_e        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          wrap_q, wrap_d;
    logic [W-1:0]  display_q, display_d;
    logic [W-1:0]  pending_q, pending_d;
    logic          load_pending_d;
    logic          frame_end;

    logic [15:0]         disp_pad;
    logic [3:0]          digit;
    logic [7:0]          seg_dec;
    logic [7:0]          seg_show;
    logic [SelWidth-1:0] sel_show;

    // wrap_q marks the first state of a new frame; outputs lag the state by one
    // cycle, so the frame boundary is visible on the outputs one cycle later.
    assign frame_end = wrap_q & enable;

    // Scan FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        if (!enable) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StBlank: begin
                    if (BLANK_CYCLES == 0 || cnt_q == BlankLast) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StShow: begin
                    if (cnt_q == DwellLast) begin
                        cnt_d   = '0;
                        state_d = (BLANK_CYCLES == 0) ? StShow : StBlank;
                        if (idx_q == LastIdx) begin
                            idx_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = StBlank;
            endcase
        end
    end

    // Double buffer: a load landing exactly on the frame boundary goes straight
    // to the display and never shows up as pending.
    always_comb begin
        display_d      = display_q;
        pending_d      = pending_q;
        load_pending_d = load_pending;
        if (frame_end) begin
            load_pending_d = 1'b0;
            if (load) begin
                display_d = number_in;
                pending_d = number_in;
            end else begin
                display_d = pending_q;
            end
        end else if (load) begin
            pending_d      = number_in;
            load_pending_d = 1'b1;
        end
    end

    // Decode from display_d so the first digit of a frame already sees the new value.
    assign disp_pad = 16'(display_d);
    assign digit    = disp_pad[{idx_q, 2'b00} +: 4];
    assign sel_show = ~(SelWidth'(1) << idx_q);

    BCD_n u_bcd (
        .bcd (digit),
        .seg (seg_dec)
    );

`ifdef DISP_LZ_SUPPRESS_EN
    logic lz_blank;
    // Digit and every higher digit zero -> leading zero; digit 0 is never suppressed.
    assign lz_blank = (idx_q != 2'd0) && ((disp_pad >> {idx_q, 2'b00}) == 16'd0);
    assign seg_show = lz_blank ? SegBlank : seg_dec;
`else
    assign seg_show = seg_dec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            idx_q        <= '0;
            wrap_q       <= 1'b0;
            display_q    <= '0;
            pending_q    <= '0;
            load_pending <= 1'b0;
            frame_done   <= 1'b0;
            io_sel       <= SelNone;
            io_seg       <= SegBlank;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wrap_q       <= wrap_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            load_pending <= load_pending_d;
            frame_done   <= frame_end;
            if (!enable || state_q == StBlank) begin
                io_sel <= SelNone;
                io_seg <= SegBlank;
            end else begin
                io_sel <= sel_show;
                io_seg <= seg_show;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with 4 digits, dwell 4, blank 2.
// Cycle c is the interval after the c-th rising edge following reset release.
module tb_display_scan_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned DWELL = 4;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = N * (DWELL + BLANK);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] number_in = 16'h0000;
    logic        load_pending;
    logic        frame_done;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] pat [16];

    display_scan_ctrl #(
        .NUMBER_OF_DIGITS (N),
        .DWELL_CYCLES     (DWELL),
        .BLANK_CYCLES     (BLANK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .number_in    (number_in),
        .load         (load),
        .load_pending (load_pending),
        .frame_done   (frame_done),
        .io_sel       (io_sel),
        .io_seg       (io_seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    // Expected select/segments at cycle c for a frame starting at cycle base.
    task automatic check_out(input string tag, input int c, input int base,
                             input logic [15:0] val);
        int o;
        int d;
        logic [3:0] es;
        logic [7:0] eg;
        logic [15:0] sh;
        o = (c - base) % FRAME;
        d = o / (DWELL + BLANK);
        if ((o % (DWELL + BLANK)) < BLANK) begin
            es = 4'hF;
            eg = 8'hFF;
        end else begin
            es = ~(4'b0001 << d);
            sh = val >> (4 * d);
            eg = pat[sh[3:0]];
        end
        check({tag, "_sel"}, 32'(io_sel), 32'(es));
        check({tag, "_seg"}, 32'(io_seg), 32'(eg));
    endtask

    initial begin
        logic [7:0] exp_hi;
        pat[0]  = 8'hC0; pat[1]  = 8'hF9; pat[2]  = 8'hA4; pat[3]  = 8'hB0;
        pat[4]  = 8'h99; pat[5]  = 8'h92; pat[6]  = 8'h82; pat[7]  = 8'hF8;
        pat[8]  = 8'h80; pat[9]  = 8'h90; pat[10] = 8'hFF; pat[11] = 8'hFF;
        pat[12] = 8'hFF; pat[13] = 8'hFF; pat[14] = 8'hFF; pat[15] = 8'hFF;

        // Reset state
        #1 rst_n = 1'b0;
        #20;
        check("rst_sel", 32'(io_sel), 32'h0000000F);
        check("rst_seg", 32'(io_seg), 32'h000000FF);
        check("rst_lp",  32'(load_pending), 32'd0);
        check("rst_fd",  32'(frame_done), 32'd0);
        release_reset();

        // Frame 1: zeros; load 1234 during cycle 10 stays pending to the frame end
        for (int c = 0; c <= 24; c++) begin
            goto(c);
            check_out("f1", c, 0, 16'h0000);
            check("f1_fd", 32'(frame_done), 32'(c == 24));
            check("f1_lp", 32'(load_pending), 32'(c >= 11 && c < 24));
            if (c == 10) begin
                number_in = 16'h1234;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end

        // Frame 2: shows 1234; loads 1111 then 2222 (last one wins)
        for (int c = 25; c <= 48; c++) begin
            goto(c);
            check_out("f2", c, 0, 16'h1234);
            check("f2_fd", 32'(frame_done), 32'(c == 48));
            check("f2_lp", 32'(load_pending), 32'(c >= 30 && c < 48));
            load = 1'b0;
            if (c == 29) begin
                number_in = 16'h1111;
                load = 1'b1;
            end
            if (c == 33) begin
                number_in = 16'h2222;
                load = 1'b1;
            end
        end

        // Frame 3: shows 2222; load 5678 sampled on the frame-end edge
        for (int c = 49; c <= 72; c++) begin
            goto(c);
            check_out("f3", c, 0, 16'h2222);
            check("f3_fd", 32'(frame_done), 32'(c == 72));
            check("f3_lp", 32'(load_pending), 32'd0);
            load = 1'b0;
            if (c == 71) begin
                number_in = 16'h5678;
                load = 1'b1;
            end
        end

        // Frame 4 shows 5678 directly
        goto(74);
        check_out("f4", 74, 0, 16'h5678);
        number_in = 16'h9999;
        load = 1'b1;
        tick();
        load = 1'b0;
        goto(76);
        check("f4_lp", 32'(load_pending), 32'd1);
        check_out("f4b", 76, 0, 16'h5678);

        // Asynchronous reset mid-SHOW: outputs dark before the next edge
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(io_sel), 32'h0000000F);
        check("arst_seg", 32'(io_seg), 32'h000000FF);
        check("arst_lp",  32'(load_pending), 32'd0);
        check("arst_fd",  32'(frame_done), 32'd0);
        release_reset();
        goto(1);
        check_out("rr", 1, 0, 16'h0000);
        goto(2);
        check_out("rr", 2, 0, 16'h0000);

        // Enable low during cycle 3, back high during cycle 8
        goto(3);
        check_out("en", 3, 0, 16'h0000);
        enable = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            goto(c);
            check("dis_sel", 32'(io_sel), 32'h0000000F);
            check("dis_seg", 32'(io_seg), 32'h000000FF);
        end
        enable = 1'b1;
        goto(9);
        check("ren_sel9", 32'(io_sel), 32'h0000000F);
        goto(10);
        check("ren_sel10", 32'(io_sel), 32'h0000000F);
        goto(11);
        check("ren_sel11", 32'(io_sel), 32'h0000000E);
        check("ren_seg11", 32'(io_seg), 32'(pat[0]));

        // Leading zeros: 0070
        goto(12);
        number_in = 16'h0070;
        load = 1'b1;
        tick();
        load = 1'b0;
        goto(33);
        check("lz_fd", 32'(frame_done), 32'd1);
`ifdef DISP_LZ_SUPPRESS_EN
        exp_hi = 8'hFF;
`else
        exp_hi = pat[0];
`endif
        goto(35);
        check("lz_sel0", 32'(io_sel), 32'h0000000E);
        check("lz_seg0", 32'(io_seg), 32'(pat[0]));
        goto(41);
        check("lz_sel1", 32'(io_sel), 32'h0000000D);
        check("lz_seg1", 32'(io_seg), 32'(pat[7]));
        goto(47);
        check("lz_sel2", 32'(io_sel), 32'h0000000B);
        check("lz_seg2", 32'(io_seg), 32'(exp_hi));
        goto(53);
        check("lz_sel3", 32'(io_sel), 32'h00000007);
        check("lz_seg3", 32'(io_seg), 32'(exp_hi));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter NUMBER_OF_DIGITS, default 4, number of scanned digits, legal range 1..4.
REQ-002 SHALL have parameter DWELL_CYCLES, default 50000, clk cycles each digit is driven, legal range >=1.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, anti-ghosting dead time before each digit, legal range >=0.
REQ-004 SHALL have ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  in  1  scan enable; low forces display dark.
REQ-006 SHALL have port number_in  in  4*NUMBER_OF_DIGITS  packed BCD, digit 0 in bits [3:0].
REQ-007 SHALL have port load  in  1  one-cycle strobe capturing number_in into pending buffer.
REQ-008 SHALL have ports: load_pending  out  1  pending value not yet shown; frame_done  out  1  one-cycle end-of-frame pulse.
REQ-009 SHALL have ports: io_sel  out  4  active-low digit select; io_seg  out  8  active-low segments.

Function
REQ-010 SHALL implement a two-state FSM: BLANK (io_sel=4'b1111, io_seg=8'hFF) and SHOW (io_sel bit idx low, io_seg = decode of display digit idx).
REQ-011 SHALL stay in BLANK exactly BLANK_CYCLES cycles, then SHOW exactly DWELL_CYCLES cycles; BLANK_CYCLES=0 skips BLANK entirely.
REQ-012 SHALL advance idx 0,1,..,NUMBER_OF_DIGITS-1 after each SHOW, wrapping to 0 after the last digit.
REQ-013 SHALL register io_sel and io_seg; io_sel bits at or above NUMBER_OF_DIGITS SHALL always be 1.
REQ-014 SHALL assert frame_done for one cycle in the cycle following the last SHOW cycle of digit NUMBER_OF_DIGITS-1.
REQ-015 SHALL hold a display register and a pending register; load copies number_in into pending and sets load_pending.
REQ-016 SHALL copy pending into the display register and clear load_pending only at frame end (same cycle frame_done asserts); no mid-frame change of displayed digits.
REQ-017 SHALL let a later load overwrite an earlier unshown pending value (last wins).
REQ-018 SHALL, when load coincides with frame end, apply the newly loaded number_in directly to the display register and leave load_pending low.
REQ-019 SHALL decode 0..9 to standard active-low patterns; codes 10..15 SHALL produce 8'hFF.
REQ-020 SHALL, when enable is low, drive 1111/FF from the next cycle and hold FSM at BLANK, idx 0, counter 0; loads remain accepted; rising enable restarts a frame at digit 0.

Reset
REQ-021 SHALL, on rst_n low, immediately set io_sel=4'b1111, io_seg=8'hFF, state BLANK, idx 0, counter 0, display and pending registers 0, load_pending 0, frame_done 0.
REQ-022 SHALL begin the first BLANK period on the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 SHALL support macro DISP_LZ_SUPPRESS_EN: when defined, a digit idx>0 whose value and all higher-index values are 0 SHALL show io_seg=8'hFF (select still driven); digit 0 always shown.
REQ-024 SHALL, when DISP_LZ_SUPPRESS_EN is undefined, display all digits unmodified, with no suppression logic synthesized.

Structure
REQ-025 SHALL place FSM state encoding, the 4-bit select width and the blank segment constant 8'hFF in shared package display_pkg.
REQ-026 SHALL use existing sub-module BCD_n for digit-to-segment decoding; counters and FSM stay in this module.

Verification (NUMBER_OF_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, enable=1)
REQ-027 SHALL cover reset release: cycles 0-1 1111/FF, 2-5 io_sel=1110, 8-11 1101, 14-17 1011, 20-23 0111, frame_done high in cycle 24 only.
REQ-028 SHALL cover load of 16'h1234 in cycle 10: digits keep 0 through frame, load_pending 1 until cycle 24; next frame digit 0 shows pattern for 4, digit 3 pattern for 1.
REQ-029 SHALL cover loads 16'h1111 (cycle 5) then 16'h2222 (cycle 9): next frame shows only 2 on all digits.
REQ-030 SHALL cover enable low in cycle 3: cycle 4 onward 1111/FF; enable high again -> 2 BLANK cycles then io_sel=1110.
REQ-031 SHALL cover rst_n low asynchronously mid-SHOW: outputs 1111/FF before next clk edge, load_pending 0, display 0.
REQ-032 SHALL cover number 16'h0070: with DISP_LZ_SUPPRESS_EN digits 3,2 show FF, digit 1 shows 7, digit 0 shows 0; without macro digits 3,2 show 0.
